// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its fetch buffer.
package ifetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HALT  = 2'd1,
    ERR   = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] INSTR_ILLEGAL_ZERO = 32'h0;
  localparam logic [31:0] PC_STEP            = 32'd4;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO of fetch entries; flush empties it and overrides a same-cycle push.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic         full_o,
  output logic         empty_o,
  output fetch_entry_t head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  fetch_entry_t mem_q [DEPTH];
  logic         do_pop;
  logic         do_push;

  // Pointers carry one extra bit so full and empty can be told apart.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= entry_i;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: PC register, fetch FSM and redirect handling in front of the fetch buffer.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  input  logic        ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        halt_o,
  output logic        err_o
);

  state_e       state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         push, flush, pop;
  logic         fifo_full, fifo_empty;
  fetch_entry_t push_entry, head;

  assign pop              = valid_o && ready_i;
  assign push_entry.pc    = pc_q;
  assign push_entry.instr = imem_instr_i;

  // A pop frees a slot in the same cycle, so a full buffer can still accept a fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (!fifo_full || pop) begin
          if (imem_instr_i != INSTR_ILLEGAL_ZERO) begin
            push = 1'b1;
            pc_d = pc_q + PC_STEP;
          end else begin
            state_d = HALT;
          end
        end
      end
      HALT:    ;
      ERR:     ;
      default: state_d = ERR;
    endcase
    if (redirect_i) begin
      flush = 1'b1;
      push  = 1'b0;
      if (redirect_pc_i[1:0] == 2'b00) begin
        pc_d    = redirect_pc_i;
        state_d = FETCH;
      end else begin
        pc_d    = pc_q;
        state_d = ERR;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  ifetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .flush_i (flush),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

  assign imem_addr_o = pc_q;
  assign instr_o     = head.instr;
  assign pc_o        = head.pc;
  assign valid_o     = !fifo_empty;
  assign halt_o      = (state_q == HALT);
  assign err_o       = (state_q == ERR);

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: streaming, stall, halt, redirect, error and mid-stream reset.
module tb_ifetch_unit;

  logic        clk;
  logic        rst_ni;
  logic        ready;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        zeroEnable;

  logic [31:0] imemAddr, imemInstr, instrOut, pcOut;
  logic        validOut, haltOut, errOut;

  logic [31:0] imemAddr2, imemInstr2, instrOut2, pcOut2;
  logic        validOut2, haltOut2, errOut2;

  int checkCount;
  int failCount;

  // Imem model: every word is address+0x1000_0001, except 0x28 which reads as zero when enabled.
  function automatic logic [31:0] imemWord(input logic [31:0] addr);
    if (zeroEnable && addr == 32'h28) return 32'h0;
    return addr + 32'h1000_0001;
  endfunction

  assign imemInstr  = imemWord(imemAddr);
  assign imemInstr2 = imemWord(imemAddr2);

  ifetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .imem_addr_o(imemAddr), .imem_instr_i(imemInstr),
    .instr_o(instrOut), .pc_o(pcOut), .valid_o(validOut), .ready_i(ready),
    .redirect_i(redirect), .redirect_pc_i(redirectPc),
    .halt_o(haltOut), .err_o(errOut)
  );

  ifetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_ni),
    .imem_addr_o(imemAddr2), .imem_instr_i(imemInstr2),
    .instr_o(instrOut2), .pc_o(pcOut2), .valid_o(validOut2), .ready_i(1'b1),
    .redirect_i(1'b0), .redirect_pc_i(32'h0),
    .halt_o(haltOut2), .err_o(errOut2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] rpc);
    ready      = rdy;
    redirect   = redir;
    redirectPc = rpc;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_valid"}, {31'd0, validOut}, 32'd0);
    checkOutput({tag, "_instr"}, instrOut, 32'd0);
    checkOutput({tag, "_pc"}, pcOut, 32'd0);
    checkOutput({tag, "_halt"}, {31'd0, haltOut}, 32'd0);
    checkOutput({tag, "_err"}, {31'd0, errOut}, 32'd0);
    checkOutput({tag, "_addr"}, imemAddr, 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount = 0;
    failCount  = 0;
    zeroEnable = 1'b1;
    rst_ni     = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0);
    stepCycle();
    checkReset("rst");
    checkOutput("rst_addr2", imemAddr2, 32'hFFFF_FFF8);

    // Streaming with halt at 0x28.
    rst_ni = 1'b1;
    #1;
    checkOutput("rel_valid", {31'd0, validOut}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      stepCycle();
      checkOutput("stream_valid", {31'd0, validOut}, 32'd1);
      checkOutput("stream_pc", pcOut, 32'(k * 4));
      checkOutput("stream_instr", instrOut, 32'(k * 4) + 32'h1000_0001);
      if (k == 0) checkOutput("wrap_pc0", pcOut2, 32'hFFFF_FFF8);
      if (k == 1) checkOutput("wrap_pc1", pcOut2, 32'hFFFF_FFFC);
      if (k == 2) checkOutput("wrap_pc2", pcOut2, 32'h0000_0000);
    end
    stepCycle();
    checkOutput("halt_valid", {31'd0, validOut}, 32'd0);
    checkOutput("halt_flag", {31'd0, haltOut}, 32'd1);
    checkOutput("halt_addr", imemAddr, 32'h28);
    stepCycle();
    checkOutput("halt_addr_hold", imemAddr, 32'h28);
    checkOutput("halt_flag_hold", {31'd0, haltOut}, 32'd1);

    // Stall with buffer full, then release.
    zeroEnable = 1'b0;
    rst_ni = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0);
    stepCycle();
    rst_ni = 1'b1;
    for (int k = 0; k < 5; k++) stepCycle();
    checkOutput("stall_addr", imemAddr, 32'h8);
    checkOutput("stall_valid", {31'd0, validOut}, 32'd1);
    checkOutput("stall_pc", pcOut, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    stepCycle();
    checkOutput("release_pc4", pcOut, 32'h4);
    stepCycle();
    checkOutput("release_pc8", pcOut, 32'h8);
    stepCycle();
    checkOutput("release_pcC", pcOut, 32'hC);

    // Redirect to 0x100 while a pop happens with two entries buffered.
    applyStimulus(1'b1, 1'b1, 32'h100);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("redir_valid", {31'd0, validOut}, 32'd0);
    checkOutput("redir_addr", imemAddr, 32'h100);
    stepCycle();
    checkOutput("redir_valid1", {31'd0, validOut}, 32'd1);
    checkOutput("redir_pc", pcOut, 32'h100);
    checkOutput("redir_instr", instrOut, 32'h1000_0101);
    stepCycle();
    checkOutput("redir_pc_next", pcOut, 32'h104);

    // Misaligned redirect, then recovery.
    applyStimulus(1'b1, 1'b1, 32'h102);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("err_flag", {31'd0, errOut}, 32'd1);
    checkOutput("err_valid", {31'd0, validOut}, 32'd0);
    checkOutput("err_addr", imemAddr, 32'h108);
    stepCycle();
    checkOutput("err_addr_hold", imemAddr, 32'h108);
    checkOutput("err_valid_hold", {31'd0, validOut}, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h40);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("recover_err", {31'd0, errOut}, 32'd0);
    checkOutput("recover_addr", imemAddr, 32'h40);
    stepCycle();
    checkOutput("recover_valid", {31'd0, validOut}, 32'd1);
    checkOutput("recover_pc", pcOut, 32'h40);
    stepCycle();
    checkOutput("prereset_pc", pcOut, 32'h44);

    // Asynchronous reset mid-stream, checked before any further clock edge.
    rst_ni = 1'b0;
    #1;
    checkReset("async_rst");

    $display("test done: total=%0d bad=%0d", checkCount, failCount);
    $finish;
  end

endmodule
